// File: rtl/count_window_capture.sv
// Captures the counter run win_start..win_stop (counter order, wrap allowed) into a FWFT FIFO.
// Define WRAP_CNT_EN to add the wrap_cnt output counting counter wraps seen during capture.
module count_window_capture #(
  parameter int CNT_W      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int WRAP_W     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CNT_W-1:0]              cnt_in,
  input  logic                          cnt_vld,
  input  logic [CNT_W-1:0]              win_start,
  input  logic [CNT_W-1:0]              win_stop,
  input  logic                          arm,
  input  logic                          abort,
  output logic [CNT_W-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow,
`ifdef WRAP_CNT_EN
  output logic [WRAP_W-1:0]             wrap_cnt,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  generate
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || WRAP_W < 1 || CNT_W < 1)
    begin : g_bad_param
      $error("count_window_capture: FIFO_DEPTH must be a power of two >= 2; widths >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, rd_inc;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [CNT_W-1:0]   data_q, data_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   mem_q [FIFO_DEPTH];

  logic push_req;
  logic flush;
  logic arm_clr;
  logic pop;
  logic full;
  logic do_push;
  logic drop;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    push_req = 1'b0;
    flush    = 1'b0;
    arm_clr  = 1'b0;
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      flush   = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (arm && !abort) begin
            state_d = S_ARMED;
            arm_clr = 1'b1;
          end
        end
        S_ARMED: begin
          if (cnt_vld && cnt_in == win_start) begin
            push_req = 1'b1;
            state_d  = (win_start == win_stop) ? S_DRAIN : S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (cnt_vld) begin
            push_req = 1'b1;
            if (cnt_in == win_stop) state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (level_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop     = out_valid && out_ready && !flush;
  assign full    = (level_q == LVL_W'(FIFO_DEPTH));
  assign do_push = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;
  assign rd_inc  = rd_ptr_q + PTR_W'(1);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    data_d   = data_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      data_d   = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_d = rd_inc;
      level_d = level_q + LVL_W'(do_push) - LVL_W'(pop);
      // Head register: a push into an (effectively) empty FIFO bypasses storage.
      if (do_push && (level_q - LVL_W'(pop)) == '0) begin
        data_d = cnt_in;
      end else if (pop && level_q > LVL_W'(1)) begin
        data_d = mem_q[rd_inc];
      end
    end
    if (arm_clr) begin
      ovf_d = 1'b0;
    end else if (drop) begin
      ovf_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      data_q   <= data_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: storage is not reset; out_data comes from the reset head register, so stale entries never show.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= cnt_in;
  end

  assign out_data   = data_q;
  assign out_valid  = (level_q != '0);
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign fifo_level = level_q;

`ifdef WRAP_CNT_EN
  logic [CNT_W-1:0]  prev_q;
  logic [WRAP_W-1:0] wrap_q, wrap_d;
  logic              in_window;
  logic              wrap_seen;

  // The sample that enters CAPTURE counts as well as every sample while capturing.
  assign in_window = !flush &&
                     ((state_q == S_CAPTURE) || (state_q == S_ARMED && state_d == S_CAPTURE));
  assign wrap_seen = cnt_vld && (cnt_in == '0) && (prev_q == '1);

  always_comb begin
    wrap_d = wrap_q;
    if (arm_clr) begin
      wrap_d = '0;
    end else if (in_window && wrap_seen && wrap_q != '1) begin
      wrap_d = wrap_q + WRAP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
      wrap_q <= '0;
    end else begin
      if (cnt_vld) prev_q <= cnt_in;
      wrap_q <= wrap_d;
    end
  end

  assign wrap_cnt = wrap_q;
`endif

endmodule

// File: tb/tb_count_window_capture.sv
// Self-checking bench for count_window_capture: directed test-plan scenarios, then random traffic,
// all compared every cycle against a queue-based behavioural model.
module tb_count_window_capture;

  localparam int CNT_W  = 4;
  localparam int DEPTH  = 4;
  localparam int WRAP_W = 8;
  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int ONES   = (1 << CNT_W) - 1;

  logic              clk;
  logic              reset;
  logic [CNT_W-1:0]  cnt_in;
  logic              cnt_vld;
  logic [CNT_W-1:0]  win_start;
  logic [CNT_W-1:0]  win_stop;
  logic              arm;
  logic              abort;
  logic [CNT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [LVL_W-1:0]  fifo_level;
`ifdef WRAP_CNT_EN
  logic [WRAP_W-1:0] wrap_cnt;
`endif

  count_window_capture #(
    .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH), .WRAP_W(WRAP_W)
  ) dut (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .cnt_vld(cnt_vld),
    .win_start(win_start), .win_stop(win_stop), .arm(arm), .abort(abort),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .overflow(overflow),
`ifdef WRAP_CNT_EN
    .wrap_cnt(wrap_cnt),
`endif
    .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: the FIFO is a queue, the capture progress a phase.
  typedef enum int {M_IDLE, M_WAIT_START, M_COLLECT, M_EMPTYING} phase_e;
  phase_e m_phase;
  int     m_q[$];
  int     m_last;
  bit     m_ovf;
  bit     m_done;
  int     m_wraps;
  int     m_prev;

  logic [CNT_W-1:0] ctr;
  int popped[$];
  int done_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_seq(input string tag, input int obs[$], input int exp[$]);
    bit same;
    same = (obs.size() == exp.size());
    if (same) foreach (exp[i]) if (obs[i] != exp[i]) same = 0;
    checks++;
    assert (same) else begin
      failures++;
      $error("FAIL %s: observed %p expected %p", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_phase = M_IDLE;
    m_last  = 0;
    m_ovf   = 0;
    m_done  = 0;
    m_wraps = 0;
    m_prev  = 0;
  endtask

  // Called just after a rising edge with the inputs that edge sampled.
  task automatic model_step();
    int pre;
    bit pop, push, counting;
    if (reset) begin
      model_reset();
      return;
    end
    pre      = m_q.size();
    pop      = (pre > 0) && out_ready;
    push     = 0;
    counting = 0;
    m_done   = 0;
    if (abort && m_phase != M_IDLE) begin
      m_q.delete();
      m_last  = 0;
      m_phase = M_IDLE;
    end else begin
      case (m_phase)
        M_IDLE: if (arm) begin
          m_phase = M_WAIT_START;
          m_ovf   = 0;
          m_wraps = 0;
        end
        M_WAIT_START: if (cnt_vld && cnt_in == win_start) begin
          push = 1;
          if (win_start == win_stop) m_phase = M_EMPTYING;
          else begin
            m_phase  = M_COLLECT;
            counting = 1;
          end
        end
        M_COLLECT: if (cnt_vld) begin
          push     = 1;
          counting = 1;
          if (cnt_in == win_stop) m_phase = M_EMPTYING;
        end
        M_EMPTYING: if (pre == 0) begin
          m_phase = M_IDLE;
          m_done  = 1;
        end
        default: ;
      endcase
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(int'(cnt_in));
        else m_ovf = 1;
      end
      if (counting && cnt_in == 0 && m_prev == ONES && m_wraps < (1 << WRAP_W) - 1) m_wraps++;
      if (m_q.size() > 0) m_last = m_q[0];
    end
    if (cnt_vld) m_prev = int'(cnt_in);
  endtask

  task automatic check_all();
    chk("out_valid",  32'(out_valid),  32'(m_q.size() > 0));
    chk("out_data",   32'(out_data),   32'(m_last));
    chk("busy",       32'(busy),       32'(m_phase != M_IDLE));
    chk("done",       32'(done),       32'(m_done));
    chk("overflow",   32'(overflow),   32'(m_ovf));
    chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
`ifdef WRAP_CNT_EN
    chk("wrap_cnt",   32'(wrap_cnt),   32'(m_wraps));
`endif
  endtask

  task automatic tick();
    if (out_valid && out_ready && !abort && !reset) popped.push_back(int'(out_data));
    @(posedge clk);
    model_step();
    #1;
    check_all();
    if (done) done_seen++;
  endtask

  // Upstream counter advances once per valid sample; gate=1 toggles cnt_vld 1,0,1,0.
  task automatic run(input int n, input bit gate);
    for (int i = 0; i < n; i++) begin
      cnt_vld = gate ? (i % 2 == 0) : 1'b1;
      cnt_in  = ctr;
      tick();
      if (cnt_vld) ctr++;
    end
  endtask

  task automatic arm_run(input bit gate);
    arm = 1'b1;
    run(1, gate);
    arm = 1'b0;
  endtask

  task automatic start_scenario(input int s, input int e, input bit rdy, input int c0);
    win_start = CNT_W'(s);
    win_stop  = CNT_W'(e);
    out_ready = rdy;
    ctr       = CNT_W'(c0);
    popped.delete();
    done_seen = 0;
  endtask

  task automatic async_reset_pulse();
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int exp_q[$];
    int n;
    reset = 1'b1; cnt_in = '0; cnt_vld = 1'b0; win_start = '0; win_stop = '0;
    arm = 1'b0; abort = 1'b0; out_ready = 1'b0; ctr = '0;
    popped.delete(); done_seen = 0;
    model_reset();
    #2;
    check_all();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fifo_level", 32'(fifo_level), 0);
    repeat (2) tick();
    reset = 1'b0;

    // Basic window 3..6 with free-flowing output.
    start_scenario(3, 6, 1'b1, 0);
    run(1, 0);
    arm_run(0);
    run(14, 0);
    exp_q = '{3, 4, 5, 6};
    chk_seq("basic_seq", popped, exp_q);
    chk("basic_done_pulses", 32'(done_seen), 1);
    chk("basic_busy_end", 32'(busy), 0);
    chk("basic_overflow", 32'(overflow), 0);

    // Backpressure: FIFO fills with 2..5, 6..9 dropped.
    start_scenario(2, 9, 1'b0, 0);
    arm_run(0);
    run(11, 0);
    chk("ovf_level_full", 32'(fifo_level), DEPTH);
    chk("ovf_sticky", 32'(overflow), 1);
    chk("ovf_still_busy", 32'(busy), 1);
    out_ready = 1'b1;
    run(8, 0);
    exp_q = '{2, 3, 4, 5};
    chk_seq("ovf_drain_seq", popped, exp_q);
    chk("ovf_done_pulses", 32'(done_seen), 1);
    arm_run(0);
    chk("ovf_cleared_by_arm", 32'(overflow), 0);
    abort = 1'b1;
    run(1, 0);
    abort = 1'b0;
    chk("abort_from_armed", 32'(busy), 0);

    // Wrapping window 14..1.
    start_scenario(14, 1, 1'b1, 10);
    arm_run(0);
    run(12, 0);
    exp_q = '{14, 15, 0, 1};
    chk_seq("wrap_seq", popped, exp_q);
    chk("wrap_done_pulses", 32'(done_seen), 1);
`ifdef WRAP_CNT_EN
    chk("wrap_count", 32'(wrap_cnt), 1);
`endif

    // Single-sample window.
    start_scenario(7, 7, 1'b1, 0);
    arm_run(0);
    run(12, 0);
    exp_q = '{7};
    chk_seq("single_seq", popped, exp_q);
    chk("single_done_pulses", 32'(done_seen), 1);

    // Abort after 5 has been pushed.
    start_scenario(2, 12, 1'b0, 0);
    arm_run(0);
    run(5, 0);
    abort = 1'b1;
    run(1, 0);
    abort = 1'b0;
    chk("abort_level", 32'(fifo_level), 0);
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_data", 32'(out_data), 0);
    chk("abort_busy", 32'(busy), 0);
    run(6, 0);
    chk("abort_no_done", 32'(done_seen), 0);

    // Asynchronous reset while capturing with three entries held.
    start_scenario(0, 15, 1'b0, 14);
    arm_run(0);
    n = 0;
    while (m_q.size() != 3 && n < 20) begin
      run(1, 0);
      n++;
    end
    chk("async_pre_level", 32'(fifo_level), 3);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_busy", 32'(busy), 0);
    chk("async_valid", 32'(out_valid), 0);
    chk("async_level", 32'(fifo_level), 0);
    check_all();
    repeat (2) tick();
    reset = 1'b0;
    start_scenario(1, 3, 1'b1, 0);
    arm_run(0);
    run(10, 0);
    exp_q = '{1, 2, 3};
    chk_seq("post_reset_seq", popped, exp_q);
    chk("post_reset_done", 32'(done_seen), 1);

    // Gated valid; a second arm mid-capture must be ignored.
    start_scenario(4, 6, 1'b1, 0);
    arm_run(1);
    run(8, 1);
    arm_run(1);
    run(10, 1);
    exp_q = '{4, 5, 6};
    chk_seq("gated_seq", popped, exp_q);
    chk("gated_done_pulses", 32'(done_seen), 1);
    chk("gated_busy_end", 32'(busy), 0);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      cnt_vld   = ($urandom_range(0, 3) != 0);
      cnt_in    = ($urandom_range(0, 7) == 0) ? CNT_W'($urandom) : ctr;
      out_ready = ($urandom_range(0, 2) != 0);
      abort     = ($urandom_range(0, 39) == 0);
      arm       = 1'b0;
      if (m_phase == M_IDLE && !abort && $urandom_range(0, 3) == 0) begin
        win_start = CNT_W'($urandom);
        win_stop  = CNT_W'($urandom);
        arm       = 1'b1;
      end
      tick();
      if (cnt_vld) ctr++;
      if ($urandom_range(0, 149) == 0) async_reset_pulse();
    end
    arm   = 1'b0;
    abort = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_window_capture.md
Name: count_window_capture

Overview:
- Downstream consumer of the free-running 4-bit event counter. Samples the counter value each time `cnt_vld` is high.
- Captures the contiguous run of values from a programmable start value through a stop value into a small first-word-fall-through (FWFT) FIFO, and drains it over a valid/ready interface.
- Provides windowed observation of the counter, analogous to gated waveform dumping, for on-chip debug and checking.

Parameters:
- CNT_W, 4, width of the counter value and of the captured data.
- FIFO_DEPTH, 4, capture FIFO entries; power of two, at least 2.
- WRAP_W, 8, width of the wrap counter (used only with WRAP_CNT_EN).

Ports:
- clk  in  1  system clock; rising edge.
- reset  in  1  reset, asynchronous, active-high.
- cnt_in  in  CNT_W  counter value from the upstream counter.
- cnt_vld  in  1  cnt_in is a valid sample this cycle.
- win_start  in  CNT_W  value that opens the capture window; must be stable while armed.
- win_stop  in  CNT_W  value that closes the capture window; must be stable while armed.
- arm  in  1  one-cycle request to start a capture; honoured only in IDLE.
- abort  in  1  cancel capture, flush FIFO.
- out_data  out  CNT_W  FIFO head value.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when a capture completes and the FIFO has drained.
- overflow  out  1  sticky; a sample was dropped because the FIFO was full.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- wrap_cnt  out  WRAP_W  wraps seen during capture (present only with WRAP_CNT_EN).

Behaviour:
- Reset: asynchronous, active-high. Applies immediately, including mid-capture.
  - Clears state to IDLE and empties the FIFO.
  - Reset values: out_valid=0, out_data=0, busy=0, done=0, overflow=0, fifo_level=0, wrap_cnt=0.
- FSM states: IDLE, ARMED, CAPTURE, DRAIN.
  - IDLE -> ARMED on arm. Arming also clears overflow and wrap_cnt; the FIFO is already empty in IDLE.
  - ARMED -> CAPTURE on cnt_vld && cnt_in==win_start. That start sample is pushed in the same cycle.
  - CAPTURE: every cnt_vld sample is pushed.
    - On cnt_vld && cnt_in==win_stop, the sample is pushed and the FSM goes to DRAIN.
    - If win_start==win_stop, ARMED goes directly to DRAIN, pushing exactly one sample.
  - DRAIN: no pushes. When fifo_level==0, go to IDLE and assert done for exactly that one cycle (registered).
    - If the stop sample was dropped and the FIFO is empty on DRAIN entry, done follows on the next cycle.
  - abort in any non-IDLE state:
    - next state IDLE, FIFO flushed, done not asserted.
    - abort has priority over arm, window matches and pop.
  - arm outside IDLE is ignored.
- FIFO behaviour (FWFT):
  - out_valid = level != 0; out_data = head entry.
  - Pop when out_valid && out_ready.
  - A sample pushed at edge N is on out_data after edge N when the FIFO was empty (1-cycle latency).
  - Simultaneous push and pop is legal at any level, including full; level is unchanged.
  - Push when full with no pop in the same cycle: the sample is dropped, overflow is set, and the FSM still honours win_stop.
  - Pointers wrap modulo FIFO_DEPTH. fifo_level ranges 0..FIFO_DEPTH.
  - out_data holds its last value when empty; it is 0 after reset or flush.
- Counter-value arithmetic: compare only, no arithmetic on cnt_in. A window that wraps (win_stop < win_start) is legal; capture follows counter order through the wrap.
- Samples with cnt_vld=0 are ignored in every state.

Optional Feature:
- Macro: WRAP_CNT_EN.
- Defined:
  - wrap_cnt port exists.
  - In CAPTURE, plus the cycle that enters CAPTURE, wrap_cnt increments on each cnt_vld sample where cnt_in==0 and the previous valid sample was all-ones. The previous valid sample is tracked in any state and cleared on reset.
  - wrap_cnt saturates at 2^WRAP_W-1, clears on arm, and holds its value in DRAIN and IDLE.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Basic window: counter 0,1,2,... with cnt_vld=1 every cycle, win_start=3, win_stop=6, out_ready=1, arm at cycle 1.
  - Response: out_data sequence 3,4,5,6 on consecutive cycles, then done pulses once, busy falls, overflow=0.
- Backpressure overflow: FIFO_DEPTH=4, start=2, stop=9, out_ready=0.
  - Response: fifo_level reaches 4 holding 2,3,4,5; samples 6..9 dropped; overflow=1; FSM in DRAIN.
  - Then raise out_ready: 2,3,4,5 drain, then done. A subsequent arm clears overflow.
- Wrapping window: start=14, stop=1, CNT_W=4.
  - Response: captured 14,15,0,1; with WRAP_CNT_EN, wrap_cnt=1.
- Single sample and abort:
  - start=stop=7: only 7 is captured, then done.
  - Second run with start=2, stop=12, abort asserted after value 5 is pushed: FIFO flushed (fifo_level=0, out_valid=0), IDLE, no done.
- Async reset mid-capture: reset asserted between clock edges while in CAPTURE with level 3.
  - Response: busy, out_valid and fifo_level go to 0 immediately, without waiting for a clock edge.
  - After release, arm starts a clean capture.
- Gated valid: cnt_vld toggling 1,0,1,0 with start=4, stop=6.
  - Response: only valid samples 4,5,6 captured; arm asserted during CAPTURE is ignored.
